// File: rtl/bigmem_banked_ctrl.sv
// bigmem_banked_ctrl: parametrised single-port memory with byte enables, a
// valid/ready request port and a registered read path of RD_LAT (1 or 2) cycles.
// After every reset an FSM clears the whole array, one entry per cycle, before
// any request is accepted.
//
// Optional feature: define MEM_PARITY_EN to store one even-parity bit per byte
// and to flag parity mismatches on reads through o_rsp_perr.
//
// Ports:
//   i_clk, i_rst_n       clock and synchronous active-low reset
//   i_req_valid/o_req_ready  request handshake (ready low while clearing)
//   i_req_we             1 = write, 0 = read
//   i_req_addr           entry address
//   i_req_wdata/i_req_be write data and byte enables
//   i_req_perr_inj       store inverted parity for the written bytes
//   o_rsp_valid          single-cycle pulse per read, RD_LAT cycles after accept
//   o_rsp_rdata          read data, held between responses
//   o_rsp_oor            response was for an out-of-range address
//   o_rsp_perr           parity mismatch on this response
//   o_init_busy          clear sequence in progress
module bigmem_banked_ctrl #(
  parameter int unsigned AW     = 10,
  parameter int unsigned DW     = 256,
  parameter int unsigned DEPTH  = (1 << AW),
  parameter int unsigned RD_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [DW-1:0]   i_req_wdata,
  input  logic [DW/8-1:0] i_req_be,
  input  logic            i_req_perr_inj,
  output logic            o_rsp_valid,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_oor,
  output logic            o_rsp_perr,
  output logic            o_init_busy
);

  localparam int unsigned NB     = DW / 8;
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] LastW  = (AW+1)'(DEPTH - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e        r_state, w_state_next;
  // One bit wider than the address so that DEPTH = 2**AW is representable.
  logic [AW:0]   r_clr_ptr;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_accept, w_wr, w_rd, w_in_range, w_rd_perr;
  logic [DW-1:0] w_rd_word;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StClear;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StClear) r_clr_ptr <= r_clr_ptr + (AW+1)'(1);
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    if (r_state == StClear && r_clr_ptr == LastW) w_state_next = StRun;
  end

  // FSM outputs
  always_comb begin
    o_req_ready = 1'b0;
    o_init_busy = 1'b0;
    unique case (r_state)
      StClear: o_init_busy = 1'b1;
      StRun:   o_req_ready = 1'b1;
      default: o_init_busy = 1'b1;
    endcase
  end

  assign w_accept   = i_req_valid & o_req_ready;
  assign w_in_range = {1'b0, i_req_addr} < DepthW;
  assign w_wr       = w_accept & i_req_we & w_in_range;
  assign w_rd       = w_accept & ~i_req_we;
  assign w_rd_word  = w_in_range ? r_mem[i_req_addr] : '0;

  always_ff @(posedge i_clk) begin
    if (r_state == StClear) begin
      r_mem[r_clr_ptr[AW-1:0]] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (i_req_be[i]) r_mem[i_req_addr][8*i +: 8] <= i_req_wdata[8*i +: 8];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_rd_par_calc;

  always_ff @(posedge i_clk) begin
    if (r_state == StClear) begin
      r_par[r_clr_ptr[AW-1:0]] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (i_req_be[i]) r_par[i_req_addr][i] <= (^i_req_wdata[8*i +: 8]) ^ i_req_perr_inj;
      end
    end
  end

  always_comb begin
    w_rd_par_calc = '0;
    for (int i = 0; i < NB; i++) w_rd_par_calc[i] = ^w_rd_word[8*i +: 8];
  end

  assign w_rd_perr = w_in_range & (|(r_par[i_req_addr] ^ w_rd_par_calc));
`else
  logic w_unused_perr_inj;
  assign w_unused_perr_inj = i_req_perr_inj;
  assign w_rd_perr         = 1'b0;
`endif

  // Read stage 1: data only loads on a read so it holds between responses;
  // flags are one-cycle qualifiers of the valid pulse.
  logic          r_v1, r_oor1, r_perr1;
  logic [DW-1:0] r_d1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_oor1  <= 1'b0;
      r_perr1 <= 1'b0;
      r_d1    <= '0;
    end else begin
      r_v1    <= w_rd;
      r_oor1  <= w_rd & ~w_in_range;
      r_perr1 <= w_rd & w_rd_perr;
      if (w_rd) r_d1 <= w_rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          r_v2, r_oor2, r_perr2;
    logic [DW-1:0] r_d2;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_v2    <= 1'b0;
        r_oor2  <= 1'b0;
        r_perr2 <= 1'b0;
        r_d2    <= '0;
      end else begin
        r_v2    <= r_v1;
        r_oor2  <= r_v1 & r_oor1;
        r_perr2 <= r_v1 & r_perr1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign o_rsp_valid = r_v2;
    assign o_rsp_rdata = r_d2;
    assign o_rsp_oor   = r_oor2;
    assign o_rsp_perr  = r_perr2;
  end else begin : g_lat1
    assign o_rsp_valid = r_v1;
    assign o_rsp_rdata = r_d1;
    assign o_rsp_oor   = r_oor1;
    assign o_rsp_perr  = r_perr1;
  end

endmodule

// File: tb/tb_bigmem_banked_ctrl.sv
// Directed bench for bigmem_banked_ctrl. Two instances share the request
// inputs: dut_a (AW=4, DEPTH=16, RD_LAT=1) and dut_b (AW=4, DEPTH=12, RD_LAT=2).
module tb_bigmem_banked_ctrl;

`ifdef MEM_PARITY_EN
  localparam bit ExpInjPerr = 1'b1;
`else
  localparam bit ExpInjPerr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_perr_inj;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        a_ready, a_rsp_valid, a_oor, a_perr, a_busy;
  logic [31:0] a_rdata;
  logic        b_ready, b_rsp_valid, b_oor, b_perr, b_busy;
  logic [31:0] b_rdata;

  int errors = 0;
  int checks = 0;

  // Values captured by read_op
  logic        oa_v, oa_oor, oa_perr, oa_v2, oa_oor2, ob_v1, ob_v, ob_oor, ob_perr;
  logic [31:0] oa_d, oa_d2, ob_d;

  always #5 clk = ~clk;

  bigmem_banked_ctrl #(.AW(4), .DW(32), .DEPTH(16), .RD_LAT(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(a_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .i_req_perr_inj(req_perr_inj), .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rdata),
    .o_rsp_oor(a_oor), .o_rsp_perr(a_perr), .o_init_busy(a_busy)
  );

  bigmem_banked_ctrl #(.AW(4), .DW(32), .DEPTH(12), .RD_LAT(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(b_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .i_req_perr_inj(req_perr_inj), .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rdata),
    .o_rsp_oor(b_oor), .o_rsp_perr(b_perr), .o_init_busy(b_busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_op(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic inj);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
    req_wdata = data; req_be = be; req_perr_inj = inj;
    tick();
    req_valid = 1'b0; req_perr_inj = 1'b0;
  endtask

  // Issues one read, captures dut_a at +1 cycle and dut_b at +2 cycles.
  task automatic read_op(input logic [3:0] addr);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    tick();
    req_valid = 1'b0;
    oa_v = a_rsp_valid; oa_d = a_rdata; oa_oor = a_oor; oa_perr = a_perr;
    ob_v1 = b_rsp_valid;
    tick();
    ob_v = b_rsp_valid; ob_d = b_rdata; ob_oor = b_oor; ob_perr = b_perr;
    oa_v2 = a_rsp_valid; oa_d2 = a_rdata; oa_oor2 = a_oor;
  endtask

  task automatic count_clear(output int ca, output int cb, output bit saw_rsp);
    int n = 0;
    ca = 0; cb = 0; saw_rsp = 1'b0;
    while (!(a_ready && b_ready) && n < 64) begin
      if (!a_ready) ca++;
      if (!b_ready) cb++;
      if (a_rsp_valid || b_rsp_valid) saw_rsp = 1'b1;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; req_perr_inj = 1'b0;
    tick(); tick();
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b want 0", a_rsp_valid); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_a_rdata: got %h want 0", a_rdata); end
    checks++; if (a_oor !== 1'b0) begin errors++; $display("FAIL reset_a_oor: got %b want 0", a_oor); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL reset_a_perr: got %b want 0", a_perr); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_a_busy: got %b want 1", a_busy); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", b_rsp_valid); end
    checks++; if (b_rdata !== 32'h0) begin errors++; $display("FAIL reset_b_rdata: got %h want 0", b_rdata); end
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL reset_b_busy: got %b want 1", b_busy); end
  endtask

  task automatic test_clear();
    int ca, cb;
    bit saw;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    rst_n = 1'b1;
    count_clear(ca, cb, saw);
    req_valid = 1'b0;
    checks++; if (ca !== 16) begin errors++; $display("FAIL clear_len_a: got %0d want 16", ca); end
    checks++; if (cb !== 12) begin errors++; $display("FAIL clear_len_b: got %0d want 12", cb); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL clear_a_busy: got %b want 0", a_busy); end
    tick(); tick(); tick();
    for (int a = 0; a < 16; a++) begin
      read_op(4'(a));
      checks++; if (oa_v !== 1'b1 || oa_d !== 32'h0 || oa_oor !== 1'b0)
        begin errors++; $display("FAIL clear_rd_a[%0d]: got v=%b d=%h oor=%b want v=1 d=0 oor=0", a, oa_v, oa_d, oa_oor); end
      checks++; if (ob_v !== 1'b1 || ob_d !== 32'h0 || ob_oor !== (a >= 12))
        begin errors++; $display("FAIL clear_rd_b[%0d]: got v=%b d=%h oor=%b want v=1 d=0 oor=%b", a, ob_v, ob_d, ob_oor, (a >= 12)); end
    end
  endtask

  task automatic test_byte_enable();
    write_op(4'd3, 32'h0000_00A5, 4'b0001, 1'b0);
    write_op(4'd3, 32'h0000_5A00, 4'b0010, 1'b0);
    read_op(4'd3);
    checks++; if (oa_v !== 1'b1 || oa_d !== 32'h0000_5AA5) begin errors++; $display("FAIL be_a: got v=%b d=%h want v=1 d=00005aa5", oa_v, oa_d); end
    checks++; if (ob_v1 !== 1'b0) begin errors++; $display("FAIL be_b_early: got valid=%b at +1 want 0", ob_v1); end
    checks++; if (ob_v !== 1'b1 || ob_d !== 32'h0000_5AA5) begin errors++; $display("FAIL be_b: got v=%b d=%h want v=1 d=00005aa5", ob_v, ob_d); end
    checks++; if (oa_v2 !== 1'b0 || oa_d2 !== 32'h0000_5AA5) begin errors++; $display("FAIL be_a_hold: got v=%b d=%h want v=0 d=00005aa5", oa_v2, oa_d2); end
    write_op(4'd7, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    write_op(4'd7, 32'h0011_0000, 4'b0100, 1'b0);
    write_op(4'd7, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    read_op(4'd7);
    checks++; if (oa_d !== 32'hDE11_BEEF) begin errors++; $display("FAIL be_mix_a: got %h want de11beef", oa_d); end
    checks++; if (ob_d !== 32'hDE11_BEEF) begin errors++; $display("FAIL be_mix_b: got %h want de11beef", ob_d); end
  endtask

  task automatic test_out_of_range();
    write_op(4'd13, 32'h0000_00FF, 4'b1111, 1'b0);
    read_op(4'd13);
    checks++; if (oa_v !== 1'b1 || oa_d !== 32'hFF || oa_oor !== 1'b0) begin errors++; $display("FAIL oor_a: got v=%b d=%h oor=%b want v=1 d=ff oor=0", oa_v, oa_d, oa_oor); end
    checks++; if (ob_v !== 1'b1 || ob_d !== 32'h0 || ob_oor !== 1'b1 || ob_perr !== 1'b0) begin errors++; $display("FAIL oor_b: got v=%b d=%h oor=%b perr=%b want v=1 d=0 oor=1 perr=0", ob_v, ob_d, ob_oor, ob_perr); end
    checks++; if (oa_oor2 !== 1'b0) begin errors++; $display("FAIL oor_a_idle: got oor=%b want 0", oa_oor2); end
    tick();
    checks++; if (b_oor !== 1'b0 || b_rdata !== 32'h0) begin errors++; $display("FAIL oor_b_idle: got oor=%b d=%h want oor=0 d=0", b_oor, b_rdata); end
    for (int a = 0; a < 12; a++) begin
      logic [31:0] exp;
      exp = (a == 3) ? 32'h0000_5AA5 : (a == 7) ? 32'hDE11_BEEF : 32'h0;
      read_op(4'(a));
      checks++; if (ob_d !== exp || ob_oor !== 1'b0) begin errors++; $display("FAIL oor_keep_b[%0d]: got d=%h oor=%b want d=%h oor=0", a, ob_d, ob_oor, exp); end
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++) write_op(4'(a), 32'(a), 4'b1111, 1'b0);
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 8); req_we = 1'b0; req_addr = 4'(i);
      tick();
      checks++; if (a_rsp_valid !== (i < 8) || (i < 8 && a_rdata !== 32'(i)))
        begin errors++; $display("FAIL b2b_a[%0d]: got v=%b d=%h want v=%b d=%h", i, a_rsp_valid, a_rdata, (i < 8), i); end
      checks++; if (b_rsp_valid !== (i >= 1 && i <= 8) || (i >= 1 && i <= 8 && b_rdata !== 32'(i - 1)))
        begin errors++; $display("FAIL b2b_b[%0d]: got v=%b d=%h want v=%b d=%h", i, b_rsp_valid, b_rdata, (i >= 1 && i <= 8), i - 1); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_parity();
    write_op(4'd5, 32'h1234_5678, 4'b1111, 1'b1);
    read_op(4'd5);
    checks++; if (oa_perr !== ExpInjPerr || oa_d !== 32'h1234_5678) begin errors++; $display("FAIL perr_inj_a: got perr=%b d=%h want perr=%b d=12345678", oa_perr, oa_d, ExpInjPerr); end
    checks++; if (ob_perr !== ExpInjPerr) begin errors++; $display("FAIL perr_inj_b: got perr=%b want %b", ob_perr, ExpInjPerr); end
    checks++; if (oa_v2 !== 1'b0 || a_perr !== 1'b0) begin errors++; $display("FAIL perr_idle_a: got v=%b perr=%b want 0 0", oa_v2, a_perr); end
    write_op(4'd5, 32'h1234_5678, 4'b1111, 1'b0);
    read_op(4'd5);
    checks++; if (oa_perr !== 1'b0) begin errors++; $display("FAIL perr_clean_a: got %b want 0", oa_perr); end
    checks++; if (ob_perr !== 1'b0) begin errors++; $display("FAIL perr_clean_b: got %b want 0", ob_perr); end
  endtask

  task automatic test_reset_mid();
    int ca, cb;
    bit saw;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 32'h2) begin errors++; $display("FAIL rmid_a_rsp: got v=%b d=%h want v=1 d=2", a_rsp_valid, a_rdata); end
    tick();
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_b_drop: got valid=%b want 0", b_rsp_valid); end
    tick();
    checks++; if (b_rsp_valid !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL rmid_b_idle: got v=%b busy=%b want v=0 busy=1", b_rsp_valid, b_busy); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rmid_a_busy: got %b want 1", a_busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_clear(ca, cb, saw);
    checks++; if (ca !== 16) begin errors++; $display("FAIL rmid_len_a: got %0d want 16", ca); end
    checks++; if (cb !== 12) begin errors++; $display("FAIL rmid_len_b: got %0d want 12", cb); end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp: got %b want 0", saw); end
    read_op(4'd2);
    checks++; if (oa_d !== 32'h0 || ob_d !== 32'h0) begin errors++; $display("FAIL rmid_cleared2: got a=%h b=%h want 0 0", oa_d, ob_d); end
    read_op(4'd5);
    checks++; if (oa_d !== 32'h0 || ob_d !== 32'h0 || oa_perr !== 1'b0) begin errors++; $display("FAIL rmid_cleared5: got a=%h b=%h perr=%b want 0 0 0", oa_d, ob_d, oa_perr); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
